alu_op_issue: RTL and testbench

//  Producer side of the execute-ALU Operation interface. Decodes ALUOp/Funct3/Funct7

---
 rtl/alu_op_issue_if.sv | 31 +++
 rtl/alu_op_issue.sv | 104 ++++++++++
 tb/tb_alu_op_issue.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_issue_if.sv
// Operation-issue bus between decode and the execute ALU.
// master = issue stage (drives Operation side), slave = decode/execute environment.
interface alu_op_issue_if #(
    parameter int OPCODE_LENGTH = 4,
    parameter int TAG_WIDTH     = 5,
    parameter int CNT_WIDTH     = 16
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               ALUOp;
    logic [2:0]               Funct3;
    logic [6:0]               Funct7;
    logic [TAG_WIDTH-1:0]     in_tag;
    logic                     out_valid;
    logic                     out_ready;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [TAG_WIDTH-1:0]     out_tag;
    logic                     illegal;
    logic [CNT_WIDTH-1:0]     illegal_count;

    modport master (
        input  flush, in_valid, ALUOp, Funct3, Funct7, in_tag, out_ready,
        output in_ready, out_valid, Operation, out_tag, illegal, illegal_count
    );

    modport slave (
        output flush, in_valid, ALUOp, Funct3, Funct7, in_tag, out_ready,
        input  in_ready, out_valid, Operation, out_tag, illegal, illegal_count
    );
endinterface

// File: rtl/alu_op_issue.sv
// ID/EX issue stage: decodes ALUOp/Funct3/Funct7 into the ALU operation code,
// holds it under a valid/ready handshake with flush, and counts illegal encodings.
module alu_op_issue #(
    parameter int OPCODE_LENGTH = 4,
    parameter int TAG_WIDTH     = 5,
    parameter int CNT_WIDTH     = 16
) (
    input  logic           clk,
    input  logic           reset,
    alu_op_issue_if.master bus
);
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011, OP_SLT = 4'b0100, OP_SUB = 4'b0110;
    localparam logic [3:0] OP_BEQ = 4'b1000, OP_BNE = 4'b1001, OP_BLT = 4'b1010;
    localparam logic [3:0] OP_BGE = 4'b1011, OP_SLL = 4'b1101, OP_SRL = 4'b1110;
    localparam logic [3:0] OP_SRA = 4'b1111;

    logic                     r_valid;
    logic [OPCODE_LENGTH-1:0] r_op;
    logic [TAG_WIDTH-1:0]     r_tag;
    logic                     r_ill;
    logic [CNT_WIDTH-1:0]     r_cnt;

    logic [3:0] w_op;
    logic       w_ill;
    logic       w_f7z;
    logic       w_f7s;
    logic       w_imm;
    logic       w_in_ready;
    logic       w_accept;

    assign w_f7z = (bus.Funct7 == 7'b0000000);
    assign w_f7s = (bus.Funct7 == 7'b0100000);
    assign w_imm = (bus.ALUOp == 2'b11);

    // Immediate forms ignore Funct7 except on shifts, where it selects SRL/SRA.
    always_comb begin
        w_op  = OP_ADD;
        w_ill = 1'b0;
        case (bus.ALUOp)
            2'b00: w_op = OP_ADD;
            2'b01: begin
                case (bus.Funct3)
                    3'b000:  w_op = OP_BEQ;
                    3'b001:  w_op = OP_BNE;
                    3'b100:  w_op = OP_BLT;
                    3'b101:  w_op = OP_BGE;
                    default: w_ill = 1'b1;
                endcase
            end
            default: begin
                case (bus.Funct3)
                    3'b000: begin
                        if (w_f7z || w_imm) w_op = OP_ADD;
                        else if (w_f7s)     w_op = OP_SUB;
                        else                w_ill = 1'b1;
                    end
                    3'b111: begin w_op = OP_AND; w_ill = !(w_f7z || w_imm); end
                    3'b110: begin w_op = OP_OR;  w_ill = !(w_f7z || w_imm); end
                    3'b100: begin w_op = OP_XOR; w_ill = !(w_f7z || w_imm); end
                    3'b010: begin w_op = OP_SLT; w_ill = !(w_f7z || w_imm); end
                    3'b001: begin w_op = OP_SLL; w_ill = !w_f7z; end
                    3'b101: begin
                        if (w_f7z)      w_op = OP_SRL;
                        else if (w_f7s) w_op = OP_SRA;
                        else            w_ill = 1'b1;
                    end
                    default: w_ill = 1'b1;
                endcase
            end
        endcase
        if (w_ill) w_op = OP_AND;
    end

    assign w_in_ready = !r_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_op    <= '0;
            r_tag   <= '0;
            r_ill   <= 1'b0;
            r_cnt   <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_op    <= OPCODE_LENGTH'(w_op);
            r_tag   <= bus.in_tag;
            r_ill   <= w_ill;
            if (w_ill && (r_cnt != '1)) r_cnt <= r_cnt + CNT_WIDTH'(1);
        end else if (r_valid && bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = r_valid;
    assign bus.Operation     = r_op;
    assign bus.out_tag       = r_tag;
    assign bus.illegal       = r_ill;
    assign bus.illegal_count = r_cnt;
endmodule

// File: tb/tb_alu_op_issue.sv
// Scoreboard bench for alu_op_issue: expected ops queued at acceptance, checked on consume.
module tb_alu_op_issue;
    localparam int OW   = 4;
    localparam int TW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [3:0]    op;
        logic [TW-1:0] tag;
        logic          ill;
    } exp_t;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    int   exp_cnt;
    exp_t q[$];

    alu_op_issue_if #(.OPCODE_LENGTH(OW), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) bus ();

    alu_op_issue #(.OPCODE_LENGTH(OW), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference decode: returns {illegal, op}
    function automatic logic [4:0] model(input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7);
        logic z, s, i;
        z = (f7 == 7'h00);
        s = (f7 == 7'h20);
        i = (a == 2'b11);
        if (a == 2'b00) return 5'b0_0010;
        if (a == 2'b01) begin
            if (f3[1] == 1'b0) return {3'b010, f3[2], f3[0]};
            return 5'b1_0000;
        end
        case (f3)
            3'd0: return (z || i) ? 5'b0_0010 : (s ? 5'b0_0110 : 5'b1_0000);
            3'd7: return (z || i) ? 5'b0_0000 : 5'b1_0000;
            3'd6: return (z || i) ? 5'b0_0001 : 5'b1_0000;
            3'd4: return (z || i) ? 5'b0_0011 : 5'b1_0000;
            3'd2: return (z || i) ? 5'b0_0100 : 5'b1_0000;
            3'd1: return z ? 5'b0_1101 : 5'b1_0000;
            3'd5: return z ? 5'b0_1110 : (s ? 5'b0_1111 : 5'b1_0000);
            default: return 5'b1_0000;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op and hold it until accepted (bounded); push expectation on accept.
    task automatic issue(input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7, input logic [TW-1:0] tag);
        logic acc;
        logic [4:0] m;
        exp_t e;
        bus.ALUOp = a; bus.Funct3 = f3; bus.Funct7 = f7; bus.in_tag = tag;
        bus.in_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            m = model(a, f3, f7);
            e.op = m[3:0]; e.tag = tag; e.ill = m[4];
            q.push_back(e);
            if (m[4] && exp_cnt != CMAX) exp_cnt++;
            chk("count_after_accept", 32'(bus.illegal_count), 32'(exp_cnt));
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready && !bus.flush) begin
            if (q.size() == 0) begin
                chk("unexpected_issue", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("issue", {23'd0, bus.illegal, bus.out_tag, bus.Operation},
                    {23'd0, e.ill, e.tag, e.op});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_fail = 0; exp_cnt = 0;
        reset = 1'b0;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.ALUOp = 2'b00; bus.Funct3 = 3'b000; bus.Funct7 = 7'h00; bus.in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_op", 32'(bus.Operation), 32'd0);
        chk("rst_tag", 32'(bus.out_tag), 32'd0);
        chk("rst_ill", 32'(bus.illegal), 32'd0);
        chk("rst_cnt", 32'(bus.illegal_count), 32'd0);
        reset = 1'b1;
        step();

        // SUB, 1-cycle latency, then drains
        bus.out_ready = 1'b1;
        issue(2'b10, 3'b000, 7'h20, 5'd3);
        chk("sub_valid", 32'(bus.out_valid), 32'd1);
        chk("sub_op", 32'(bus.Operation), 32'b0110);
        step();
        chk("sub_drained", 32'(bus.out_valid), 32'd0);

        // SRAI held under a 3-cycle stall
        bus.out_ready = 1'b0;
        issue(2'b11, 3'b101, 7'h20, 5'd7);
        for (int k = 0; k < 3; k++) begin
            chk("stall_op", 32'(bus.Operation), 32'b1111);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        chk("stall_drained", 32'(bus.out_valid), 32'd0);

        // Illegal branch encoding
        issue(2'b01, 3'b110, 7'h00, 5'd1);
        chk("ill_flag", 32'(bus.illegal), 32'd1);
        chk("ill_op", 32'(bus.Operation), 32'd0);
        chk("ill_cnt", 32'(bus.illegal_count), 32'd1);

        // Push the counter into saturation and beyond
        for (int k = 0; k < CMAX + 1; k++) issue(2'b10, 3'b011, 7'h00, TW'(k));
        chk("cnt_saturated", 32'(bus.illegal_count), 32'(CMAX));
        step();

        // Flush while holding, with ALUOp=00 incoming
        bus.out_ready = 1'b0;
        issue(2'b00, 3'b111, 7'h7f, 5'd9);
        exp_cnt = CMAX;
        bus.in_valid = 1'b1; bus.ALUOp = 2'b00; bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready_stalled", 32'(bus.in_ready), 32'd0);
        void'(q.pop_front());
        step();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_cnt", 32'(bus.illegal_count), 32'(exp_cnt));

        // Flush of an incoming op while empty
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.ALUOp = 2'b10; bus.Funct3 = 3'b000; bus.Funct7 = 7'h20;
        bus.in_tag = 5'd30; bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready_empty", 32'(bus.in_ready), 32'd1);
        step();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_drop_valid", 32'(bus.out_valid), 32'd0);

        // Back-to-back stream, no bubbles
        issue(2'b10, 3'b111, 7'h00, 5'd10);
        chk("stream_valid0", 32'(bus.out_valid), 32'd1);
        issue(2'b11, 3'b110, 7'h55, 5'd11);
        chk("stream_valid1", 32'(bus.out_valid), 32'd1);
        issue(2'b11, 3'b001, 7'h00, 5'd12);
        chk("stream_valid2", 32'(bus.out_valid), 32'd1);
        issue(2'b01, 3'b001, 7'h33, 5'd13);
        chk("stream_valid3", 32'(bus.out_valid), 32'd1);
        step();
        chk("stream_drained", 32'(bus.out_valid), 32'd0);

        // Random ops under random back-pressure
        for (int n = 0; n < 60; n++) begin
            logic [6:0] f7;
            case ($urandom_range(2))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            bus.out_ready = 1'($urandom);
            fork
                issue(2'($urandom), 3'($urandom), f7, TW'($urandom));
                begin
                    for (int k = 0; k < 20; k++) begin
                        @(posedge clk);
                        #1;
                        bus.out_ready = ($urandom_range(3) != 0);
                    end
                end
            join_any
            disable fork;
            if ($urandom_range(3) == 0) step();
        end
        bus.out_ready = 1'b1;
        repeat (3) step();
        chk("rand_queue_empty", 32'(q.size()), 32'd0);

        // Async reset during a stall
        bus.out_ready = 1'b0;
        issue(2'b10, 3'b101, 7'h20, 5'd21);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_stall_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_stall_op", 32'(bus.Operation), 32'd0);
        chk("rst_stall_cnt", 32'(bus.illegal_count), 32'd0);
        q.delete();
        exp_cnt = 0;
        step();
        reset = 1'b1;
        step();
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
